reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the ALU. The two read ports drive aluSrc1 and (via the immediate mux) aluSrc2.
- The write port accepts the writeback value, which is the ALU result or memory data, selected outside this block.
- Register 0 is hardwired to zero. The stack pointer register gets a non-zero reset value.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- SP_IDX, 29, index of the stack-pointer register.
- SP_INIT, 128, reset value loaded into register SP_IDX.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- RSaddr_i  input  ADDR_W  read port 1 index.
- RTaddr_i  input  ADDR_W  read port 2 index.
- RDaddr_i  input  ADDR_W  write index.
- RDdata_i  input  DATA_W  write data.
- RegWrite_i  input  1  write enable.
- RSdata_o  output  DATA_W  read port 1 data; feeds ALU aluSrc1.
- RTdata_o  output  DATA_W  read port 2 data; feeds ALU source mux.
- wr_ack_o  output  1  registered pulse: a write was committed last cycle.
- wr_cnt_o  output  16  registered count of committed writes.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high. It is sampled only on the rising edge of clk_i; there is no asynchronous path.
- Reset, on any edge with rst_i=1:
  - every register is cleared to 0, except register SP_IDX, which loads SP_INIT;
  - wr_ack_o is cleared to 0 and wr_cnt_o to 0;
  - RegWrite_i is ignored on that edge.
- Reset mid-operation: a write presented on the same edge as an asserted rst_i is discarded. Reset wins.
- Reads:
  - combinational, zero latency; RSdata_o and RTdata_o follow the address inputs within the same cycle;
  - both ports may address the same register;
  - index 0 always returns 0.
- Write:
  - on a rising edge with rst_i=0 and RegWrite_i=1, RDdata_i is stored into register RDaddr_i;
  - the value is visible on the read ports from the next cycle (see Optional Feature for the same-cycle case).
- Write to index 0:
  - storage is unchanged and register 0 stays 0;
  - the write still counts as not committed, so wr_ack_o=0 and wr_cnt_o does not increment.
- Write to SP_IDX: treated as a normal register; the reset value applies only at reset.
- wr_ack_o: 1 for exactly one cycle after each committed write (RegWrite_i=1, RDaddr_i!=0, rst_i=0), otherwise 0. Back-to-back writes hold it high continuously.
- wr_cnt_o: increments by 1 per committed write. Wraps from 16'hFFFF to 16'h0000 with no saturation and no flag.
- Same-cycle read/write to the same index, feature disabled: the read returns the old value, and the new value appears the following cycle.
- Unknown or X addresses are not defined; the verification bench must not drive them.
- No stall or handshake input. The block accepts one write per cycle unconditionally.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: when RegWrite_i=1, rst_i=0 and RDaddr_i!=0, any read port whose address equals RDaddr_i returns RDdata_i in the same cycle (write-through forwarding). Index 0 still reads 0. While rst_i=1, reads return current storage with no bypass.
- Undefined: no forwarding; reads always return stored contents, as described under Behaviour.

Test Plan:
1. Reset: assert rst_i for 1 edge, then read all 32 indices -> every register reads 0 except r29 = 128; wr_cnt_o=0, wr_ack_o=0.
2. Write r5=0x7FFFFFFF and r6=0x00000001 on consecutive edges, then RSaddr=5, RTaddr=6 -> RSdata_o=0x7FFFFFFF, RTdata_o=0x00000001; wr_ack_o high for 2 cycles; wr_cnt_o=2. Downstream ALU ADD reports overflow=1.
3. Write 0xDEADBEEF to r0 -> r0 still reads 0; wr_ack_o=0; wr_cnt_o unchanged.
4. Same-cycle read/write: RDaddr=RSaddr=7, RDdata=0x12345678, old r7=0 -> without the macro RSdata_o=0 in that cycle and 0x12345678 the next; with REG_FILE_WRITE_BYPASS_EN, 0x12345678 in the same cycle.
5. rst_i=1 together with RegWrite_i=1, RDaddr=3, RDdata=0xFF -> r3 reads 0 afterwards; wr_cnt_o=0.
6. Preload wr_cnt_o to 0xFFFF with 65535 commits, then 1 more write -> wr_cnt_o=0x0000 and wr_ack_o=1.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// 2-read / 1-write register file: r0 reads as zero, the stack pointer resets to SP_INIT.
// Optional same-cycle write forwarding on the read ports: REG_FILE_WRITE_BYPASS_EN.
module reg_file_2r1w #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter int                 SP_IDX  = 29,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(128)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RDdata_i,
  input  logic              RegWrite_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic              wr_ack_o,
  output logic [15:0]       wr_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              commit;
  logic              wr_ack_q, wr_ack_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;

  // Writes to r0 are dropped entirely and do not count as committed.
  assign commit = RegWrite_i && !rst_i && (RDaddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (commit) begin
      regs_q[RDaddr_i] <= RDdata_i;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = RSaddr_i;
  assign rd_addr[1] = RTaddr_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rport
    logic bypass_hit;
`ifdef REG_FILE_WRITE_BYPASS_EN
    assign bypass_hit = commit && (rd_addr[gi] == RDaddr_i);
`else
    assign bypass_hit = 1'b0;
`endif
    assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                         bypass_hit          ? RDdata_i :
                                               regs_q[rd_addr[gi]];
  end

  assign RSdata_o = rd_data[0];
  assign RTdata_o = rd_data[1];

  always_comb begin
    wr_ack_d = commit;
    wr_cnt_d = commit ? wr_cnt_q + 16'd1 : wr_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ack_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      wr_ack_q <= wr_ack_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_ack_o = wr_ack_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: vector table plus reset, r0 and counter-wrap sequences.
module tb_reg_file_2r1w;

`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic [31:0] RDdata_i;
  logic        RegWrite_i;
  logic [31:0] RSdata_o, RTdata_o;
  logic        wr_ack_o;
  logic [15:0] wr_cnt_o;

  reg_file_2r1w dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .RSaddr_i   (RSaddr_i),
    .RTaddr_i   (RTaddr_i),
    .RDaddr_i   (RDaddr_i),
    .RDdata_i   (RDdata_i),
    .RegWrite_i (RegWrite_i),
    .RSdata_o   (RSdata_o),
    .RTdata_o   (RTdata_o),
    .wr_ack_o   (wr_ack_o),
    .wr_cnt_o   (wr_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic        ack;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic        exp_ack;
    logic [15:0] exp_cnt;
    string       name;
  } vec_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_txn = 0;
  logic [31:0] mdl [32];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Expected outputs are queued at drive time and checked on the following falling edge.
  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb_q.pop_front();
    cmp({e.name, ".rs"},  RSdata_o, e.rs);
    cmp({e.name, ".rt"},  RTdata_o, e.rt);
    cmp({e.name, ".ack"}, {31'd0, wr_ack_o}, {31'd0, e.ack});
    cmp({e.name, ".cnt"}, {16'd0, wr_cnt_o}, {16'd0, e.cnt});
    $display("txn %0d %s: rs=0x%08h rt=0x%08h ack=%0b cnt=0x%04h",
             n_txn, e.name, RSdata_o, RTdata_o, wr_ack_o, wr_cnt_o);
    n_txn++;
  endtask

  task automatic cyc(input vec_t v);
    exp_t e;
    rst_i      = v.rst;
    RegWrite_i = v.we;
    RDaddr_i   = v.rd;
    RDdata_i   = v.wd;
    RSaddr_i   = v.rs;
    RTaddr_i   = v.rt;
    e.rs = v.exp_rs; e.rt = v.exp_rt; e.ack = v.exp_ack; e.cnt = v.exp_cnt; e.name = v.name;
    sb_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] rd,
                              input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [31:0] ers, input logic [31:0] ert,
                              input logic eack, input logic [15:0] ecnt, input string name);
    vec_t v;
    v.rst = rst; v.we = we; v.rd = rd; v.wd = wd; v.rs = rs; v.rt = rt;
    v.exp_rs = ers; v.exp_rt = ert; v.exp_ack = eack; v.exp_cnt = ecnt; v.name = name;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    // Each row: inputs for one cycle, and outputs expected during that same cycle.
    tbl[0]  = mk(0, 1, 5,  32'h7FFFFFFF, 5, 6,  BYP ? 32'h7FFFFFFF : 32'h0, 32'h0, 0, 16'd0, "wr_r5");
    tbl[1]  = mk(0, 1, 6,  32'h00000001, 5, 6,  32'h7FFFFFFF, BYP ? 32'h1 : 32'h0, 1, 16'd1, "wr_r6");
    tbl[2]  = mk(0, 0, 0,  32'h0,        5, 6,  32'h7FFFFFFF, 32'h1,        1, 16'd2, "rd_r5_r6");
    tbl[3]  = mk(0, 0, 0,  32'h0,        5, 5,  32'h7FFFFFFF, 32'h7FFFFFFF, 0, 16'd2, "rd_same");
    tbl[4]  = mk(0, 1, 0,  32'hDEADBEEF, 0, 0,  32'h0,        32'h0,        0, 16'd2, "wr_r0");
    tbl[5]  = mk(0, 0, 0,  32'h0,        0, 29, 32'h0,        32'h80,       0, 16'd2, "rd_r0_sp");
    tbl[6]  = mk(0, 1, 7,  32'h12345678, 7, 7,  BYP ? 32'h12345678 : 32'h0,
                 BYP ? 32'h12345678 : 32'h0, 0, 16'd2, "rw_r7");
    tbl[7]  = mk(0, 0, 0,  32'h0,        7, 5,  32'h12345678, 32'h7FFFFFFF, 1, 16'd3, "rd_r7");
    tbl[8]  = mk(0, 1, 29, 32'h00001000, 29, 0, BYP ? 32'h1000 : 32'h80, 32'h0, 0, 16'd3, "wr_sp");
    tbl[9]  = mk(0, 0, 0,  32'h0,        29, 29, 32'h1000,    32'h1000,     1, 16'd4, "rd_sp");
    tbl[10] = mk(1, 1, 3,  32'h000000FF, 3, 5,  32'h0,        32'h7FFFFFFF, 0, 16'd4, "rst_wr_r3");
    tbl[11] = mk(0, 0, 0,  32'h0,        3, 29, 32'h0,        32'h80,       0, 16'd0, "post_rst");
    tbl[12] = mk(0, 0, 0,  32'h0,        5, 7,  32'h0,        32'h0,        0, 16'd0, "post_rst2");

    rst_i = 1'b1; RegWrite_i = 1'b0; RDaddr_i = '0; RDdata_i = '0; RSaddr_i = '0; RTaddr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < 32; i++) begin
      logic [31:0] ea, eb;
      ea = (i == 29) ? 32'd128 : 32'd0;
      eb = ((31 - i) == 29) ? 32'd128 : 32'd0;
      cyc(mk(0, 0, 0, 32'h0, 5'(i), 5'(31 - i), ea, eb, 0, 16'd0, $sformatf("reset_r%0d", i)));
    end

    for (int i = 0; i < 13; i++) cyc(tbl[i]);

    // Counter wrap: 65535 commits bring the count to 0xFFFF, the next one wraps it.
    for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'd128 : 32'd0;
    for (int i = 0; i < 65535; i++) begin
      rst_i      = 1'b0;
      RegWrite_i = 1'b1;
      RDaddr_i   = 5'((i % 31) + 1);
      RDdata_i   = 32'(i) * 32'h9E3779B1;
      mdl[RDaddr_i] = RDdata_i;
      @(posedge clk);
      #1;
    end
    cyc(mk(0, 0, 0, 32'h0, 1, 29, mdl[1], mdl[29], 1, 16'hFFFF, "preload"));
    cyc(mk(0, 1, 10, 32'hA5A5A5A5, 10, 1, BYP ? 32'hA5A5A5A5 : mdl[10], mdl[1], 0, 16'hFFFF, "wrap_wr"));
    cyc(mk(0, 0, 0, 32'h0, 10, 10, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 16'h0000, "wrap_ack"));
    cyc(mk(0, 0, 0, 32'h0, 31, 0, mdl[31], 32'h0, 0, 16'h0000, "wrap_idle"));

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
